// File: rtl/check_prime_param.sv
// Sequential trial-division primality checker for WIDTH-bit operands using a bit-serial
// restoring remainder unit. Define CHECK_PRIME_CONST_TIME_EN for data-independent latency.
module check_prime_param #(
  parameter int WIDTH     = 8,
  parameter int SKIP_EVEN = 1,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] num,
  output logic             busy,
  output logic             finish,
  output logic             is_prime,
  output logic [WIDTH-1:0] factor,
  output logic [CNT_W-1:0] cycles
);

  typedef enum logic [2:0] {S_IDLE, S_SPECIAL, S_DIVIDE, S_EVAL, S_DONE} state_t;

  localparam int               IDX_W  = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] D_STEP = (SKIP_EVEN != 0) ? WIDTH'(2) : WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             prime_q, prime_d;
  logic [WIDTH-1:0] factor_q, factor_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [WIDTH-1:0] nd;

`ifdef CHECK_PRIME_CONST_TIME_EN
  localparam logic [WIDTH-1:0] D_MAX = WIDTH'((1 << (WIDTH/2)) - 1);
  logic found_q, found_d;
  logic hit;
`else
  function automatic logic [2*WIDTH-1:0] square(input logic [WIDTH-1:0] d);
    return {{WIDTH{1'b0}}, d} * {{WIDTH{1'b0}}, d};
  endfunction
`endif

  // One restoring step: shift in the next operand bit, subtract the divisor if it fits.
  function automatic logic [WIDTH:0] rem_step(input logic [WIDTH-1:0] r, input logic b,
                                              input logic [WIDTH-1:0] d);
    logic [WIDTH:0] s;
    s = {r, b};
    if (s >= {1'b0, d}) s = s - {1'b0, d};
    return s;
  endfunction

  function automatic logic [WIDTH-1:0] next_div(input logic [WIDTH-1:0] d);
    return (d == WIDTH'(2)) ? WIDTH'(3) : d + D_STEP;
  endfunction

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    d_d      = d_q;
    r_d      = r_q;
    idx_d    = idx_q;
    prime_d  = prime_q;
    factor_d = factor_q;
    cycles_d = cycles_q;
    nd       = next_div(d_q);
`ifdef CHECK_PRIME_CONST_TIME_EN
    found_d  = found_q;
    hit      = (r_q == '0) && (d_q < n_q) && !found_q;
`endif
    if (state_q != S_IDLE && state_q != S_DONE && cycles_q != '1)
      cycles_d = cycles_q + CNT_W'(1);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d      = num;
          // counting starts with the first busy cycle so the finish cycle reads L
          cycles_d = CNT_W'(1);
          state_d  = S_SPECIAL;
        end
      end
      S_SPECIAL: begin
        d_d     = WIDTH'(2);
        r_d     = '0;
        idx_d   = IDX_W'(WIDTH - 1);
        state_d = S_DIVIDE;
`ifdef CHECK_PRIME_CONST_TIME_EN
        found_d = 1'b0;
`else
        if (n_q < WIDTH'(2)) begin
          prime_d  = 1'b0;
          factor_d = '0;
          state_d  = S_DONE;
        end else if (n_q < WIDTH'(4)) begin
          prime_d  = 1'b1;
          factor_d = n_q;
          state_d  = S_DONE;
        end
`endif
      end
      S_DIVIDE: begin
        r_d   = rem_step(r_q[WIDTH-1:0], n_q[idx_q], d_q);
        idx_d = idx_q - IDX_W'(1);
        if (idx_q == '0) state_d = S_EVAL;
      end
      S_EVAL: begin
        r_d   = '0;
        idx_d = IDX_W'(WIDTH - 1);
`ifdef CHECK_PRIME_CONST_TIME_EN
        if (hit) begin
          found_d  = 1'b1;
          prime_d  = 1'b0;
          factor_d = d_q;
        end
        if (nd > D_MAX) begin
          state_d = S_DONE;
          if (!(found_q || hit)) begin
            prime_d  = (n_q >= WIDTH'(2));
            factor_d = (n_q >= WIDTH'(2)) ? n_q : '0;
          end
        end else begin
          d_d     = nd;
          state_d = S_DIVIDE;
        end
`else
        if (r_q == '0) begin
          prime_d  = 1'b0;
          factor_d = d_q;
          state_d  = S_DONE;
        end else if (square(nd) > {{WIDTH{1'b0}}, n_q}) begin
          prime_d  = 1'b1;
          factor_d = n_q;
          state_d  = S_DONE;
        end else begin
          d_d     = nd;
          state_d = S_DIVIDE;
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      prime_q  <= 1'b0;
      factor_q <= '0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      prime_q  <= prime_d;
      factor_q <= factor_d;
      cycles_q <= cycles_d;
    end
  end

  always_ff @(posedge clk) begin
    n_q   <= n_d;
    d_q   <= d_d;
    r_q   <= r_d;
    idx_q <= idx_d;
`ifdef CHECK_PRIME_CONST_TIME_EN
    found_q <= found_d;
`endif
  end

  assign busy     = (state_q != S_IDLE);
  assign finish   = (state_q == S_DONE);
  assign is_prime = prime_q;
  assign factor   = factor_q;
  assign cycles   = cycles_q;

endmodule
